// File: rtl/uart_tx_arbiter_if.sv
// Request/txModule handshake bundle for uart_tx_arbiter. The slave modport is the
// arbiter's view; master is the user/txModule side that drives requests and done.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ack;
  logic [7:0]           tx_data;
  logic                 tx_en_sig;
  logic                 tx_done_sig;
  logic                 busy;
  logic                 timeout_err;

  modport slave (
    input  req, req_data, tx_done_sig,
    output req_ack, tx_data, tx_en_sig, busy, timeout_err
  );

  modport master (
    output req, req_data, tx_done_sig,
    input  req_ack, tx_data, tx_en_sig, busy, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART transmitter; req->tx_en_sig latency 1 clk, one byte per grant.
// Requesters are held off by keeping req high until their req_ack pulse; a watchdog drops stuck sends.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input logic               clk,
  input logic               rstn,
  uart_tx_arbiter_if.slave  bus
);
  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_DONE, ST_GAP} state_t;

  state_t             r_state;
  logic [PW-1:0]      r_ptr;
  logic [7:0]         r_tx_data;
  logic               r_tx_en;
  logic [NUM_REQ-1:0] r_ack;
  logic               r_to_err;
  logic [31:0]        r_wd_cnt;
  logic [31:0]        r_gap_cnt;

  state_t             w_state_nxt;
  logic [PW-1:0]      w_ptr_nxt;
  logic [7:0]         w_tx_data_nxt;
  logic               w_tx_en_nxt;
  logic [NUM_REQ-1:0] w_ack_nxt;
  logic               w_to_err_nxt;
  logic [31:0]        w_wd_cnt_nxt;
  logic [31:0]        w_gap_cnt_nxt;
  logic               w_hit;
  logic [PW-1:0]      w_win;
  logic [7:0]         w_win_dat;
  logic               w_expire;

  // Two passes give the rotating priority: indices above the pointer first, then the wrap.
  always_comb begin
    w_hit     = 1'b0;
    w_win     = r_ptr;
    w_win_dat = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_hit && bus.req[i] && (PW'(i) > r_ptr)) begin
        w_hit     = 1'b1;
        w_win     = PW'(i);
        w_win_dat = bus.req_data[8*i +: 8];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_hit && bus.req[i] && (PW'(i) <= r_ptr)) begin
        w_hit     = 1'b1;
        w_win     = PW'(i);
        w_win_dat = bus.req_data[8*i +: 8];
      end
    end
  end

  assign w_expire = (TIMEOUT_CYCLES != 0) && (r_wd_cnt == 32'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_tx_data_nxt = r_tx_data;
    w_tx_en_nxt   = r_tx_en;
    w_ack_nxt     = '0;
    w_to_err_nxt  = 1'b0;
    w_wd_cnt_nxt  = r_wd_cnt;
    w_gap_cnt_nxt = r_gap_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_hit) begin
          w_state_nxt   = ST_SEND;
          w_ptr_nxt     = w_win;
          w_tx_data_nxt = w_win_dat;
          w_tx_en_nxt   = 1'b1;
          w_wd_cnt_nxt  = '0;
        end
      end
      ST_SEND: begin
        // A done pulse on the expiry cycle still counts as a normal completion.
        if (bus.tx_done_sig || w_expire) begin
          w_state_nxt      = ST_DONE;
          w_tx_en_nxt      = 1'b0;
          w_ack_nxt[r_ptr] = 1'b1;
          w_to_err_nxt     = !bus.tx_done_sig;
        end else begin
          w_wd_cnt_nxt = r_wd_cnt + 32'd1;
        end
      end
      ST_DONE: begin
        w_gap_cnt_nxt = '0;
        w_state_nxt   = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
      end
      ST_GAP: begin
        if (r_gap_cnt == 32'(GAP_CYCLES - 1)) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + 32'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      r_ptr     <= PW'(NUM_REQ - 1);
      r_tx_data <= 8'h00;
      r_tx_en   <= 1'b0;
      r_ack     <= '0;
      r_to_err  <= 1'b0;
      r_wd_cnt  <= '0;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_tx_data <= w_tx_data_nxt;
      r_tx_en   <= w_tx_en_nxt;
      r_ack     <= w_ack_nxt;
      r_to_err  <= w_to_err_nxt;
      r_wd_cnt  <= w_wd_cnt_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
    end
  end

  assign bus.tx_data     = r_tx_data;
  assign bus.tx_en_sig   = r_tx_en;
  assign bus.req_ack     = r_ack;
  assign bus.timeout_err = r_to_err;
  assign bus.busy        = (r_state != ST_IDLE);
endmodule
